// File: rtl/dmaw_pkg.sv
// rtl/dmaw_pkg.sv - shared FSM state and beat-count / strobe-mask helpers for dmaw_wgen
package dmaw_pkg;

  // Widest beat the strobe helper can describe (AXI_DW up to 1024)
  localparam int MAX_BYTES = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  // Beats touched by a job starting at byte offset off within the first beat.
  // 33-bit sum so a full 4 GiB length cannot wrap.
  function automatic logic [32:0] beat_count(input logic [31:0] off, input logic [31:0] len,
                                             input int bytes, input int lbits);
    logic [32:0] sum;
    sum = {1'b0, off} + {1'b0, len} + 33'(bytes - 1);
    return sum >> lbits;
  endfunction

  // keep_high=1: enable lanes at and above off (first beat).
  // keep_high=0: enable lanes at and below off (final beat).
  function automatic logic [MAX_BYTES-1:0] strb_mask(input logic [6:0] off, input logic keep_high);
    logic [MAX_BYTES-1:0] m;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = keep_high ? (i >= int'(off)) : (i <= int'(off));
    end
    return m;
  endfunction

endpackage

// File: rtl/dmaw_skid.sv
// rtl/dmaw_skid.sv - two-entry registered skid buffer between the beat generator and the W port
// Push only when count_o < 2, or together with a pop; push+pop when full keeps two entries.
module dmaw_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] s_tdata_i,
  input  logic         s_tvalid_i,
  output logic [W-1:0] m_tdata_o,
  output logic         m_tvalid_o,
  input  logic         m_tready_i,
  output logic [1:0]   count_o
);

  logic [1:0]   count_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         pop;

  assign pop        = (count_q != 2'd0) && m_tready_i;
  assign m_tvalid_o = (count_q != 2'd0);
  assign m_tdata_o  = head_q;
  assign count_o    = count_q;

  // head_q is the visible beat; tail_q holds the overflow beat while the head stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({s_tvalid_i, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= s_tdata_i;
          else                 tail_q <= s_tdata_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= s_tdata_i;
          end else begin
            head_q <= s_tdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmaw_wgen.sv
// rtl/dmaw_wgen.sv - AXI write-data beat generator with edge strobes and burst-boundary wlast
// Optional DMAW_WGEN_LASTCHK_EN: raise sticky err when src_last disagrees with the final beat.
module dmaw_wgen
  import dmaw_pkg::*;
#(
  parameter int AXI_DW    = 128,
  parameter int AXI_BYTES = AXI_DW / 8,
  parameter int BL        = 16,
  parameter int L         = $clog2(AXI_BYTES),
  parameter int B         = $clog2(BL) + L
) (
  input  logic                 usr_clk,
  input  logic                 usr_reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [31:0]          cfg_sa,
  input  logic [31:0]          cfg_len,
  input  logic [AXI_DW-1:0]    src_data,
  input  logic                 src_last,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [AXI_DW-1:0]    usr_wdata,
  output logic [AXI_BYTES-1:0] usr_wstrb,
  output logic                 usr_wlast,
  output logic                 usr_wvalid,
  input  logic                 usr_wready,
  output logic                 done,
  output logic                 err
);

  localparam int PW = AXI_DW + AXI_BYTES + 1;

  state_e         state_q;
  logic [32:0]    total_q;
  logic [32:0]    cnt_q;
  logic [31:0]    addr_q;
  logic [L-1:0]   start_off_q;
  logic [L-1:0]   end_off_q;
  logic           done_q;
`ifdef DMAW_WGEN_LASTCHK_EN
  logic           err_q;
`endif

  logic [1:0]           skid_cnt;
  logic [PW-1:0]        skid_out;
  logic                 skid_valid;
  logic                 src_fire;
  logic                 usr_fire;
  logic                 is_first;
  logic                 is_final;
  logic                 beat_last;
  logic [31:0]          addr_nxt;
  logic [L-1:0]         end_off_d;
  logic [AXI_BYTES-1:0] strb_first;
  logic [AXI_BYTES-1:0] strb_final;
  logic [AXI_BYTES-1:0] beat_strb;

  assign cfg_ready  = (state_q == IDLE);
  assign src_ready  = (state_q == RUN) && (skid_cnt != 2'd2) && (cnt_q < total_q);
  assign src_fire   = src_valid && src_ready;
  assign usr_fire   = skid_valid && usr_wready;
  assign is_first   = (cnt_q == 33'd0);
  assign is_final   = (cnt_q == total_q - 33'd1);
  assign addr_nxt   = addr_q + 32'(AXI_BYTES);
  assign end_off_d  = cfg_sa[L-1:0] + cfg_len[L-1:0] - L'(1);
  assign strb_first = AXI_BYTES'(strb_mask(7'(start_off_q), 1'b1));
  assign strb_final = AXI_BYTES'(strb_mask(7'(end_off_q), 1'b0));

  // Strobe and wlast for the beat being accepted, from its position in the job
  always_comb begin
    beat_strb = '1;
    if (is_first) beat_strb = beat_strb & strb_first;
    if (is_final) beat_strb = beat_strb & strb_final;
    beat_last = is_final || (addr_nxt[B-1:0] == '0);
  end

  // Job sequencing: latch config, count accepted beats, drain, pulse done
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state_q     <= IDLE;
      total_q     <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      start_off_q <= '0;
      end_off_q   <= '0;
      done_q      <= 1'b0;
`ifdef DMAW_WGEN_LASTCHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            start_off_q <= cfg_sa[L-1:0];
            end_off_q   <= end_off_d;
            addr_q      <= cfg_sa & ~32'(AXI_BYTES - 1);
            total_q     <= beat_count(32'(cfg_sa[L-1:0]), cfg_len, AXI_BYTES, L);
            cnt_q       <= '0;
`ifdef DMAW_WGEN_LASTCHK_EN
            err_q       <= 1'b0;
`endif
            if (cfg_len == 32'd0) done_q  <= 1'b1;
            else                  state_q <= RUN;
          end
        end
        RUN: begin
          if (src_fire) begin
            cnt_q  <= cnt_q + 33'd1;
            addr_q <= addr_nxt;
            if (is_final) state_q <= FLUSH;
`ifdef DMAW_WGEN_LASTCHK_EN
            if (src_last != is_final) err_q <= 1'b1;
`endif
          end
        end
        FLUSH: begin
          // No pushes happen here, so the beat leaving a one-entry buffer is the last one
          if (usr_fire && (skid_cnt == 2'd1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  dmaw_skid #(.W(PW)) u_skid (
    .clk_i      (usr_clk),
    .rst_i      (usr_reset),
    .s_tdata_i  ({beat_strb, beat_last, src_data}),
    .s_tvalid_i (src_fire),
    .m_tdata_o  (skid_out),
    .m_tvalid_o (skid_valid),
    .m_tready_i (usr_wready),
    .count_o    (skid_cnt)
  );

  assign usr_wvalid = skid_valid;
  assign {usr_wstrb, usr_wlast, usr_wdata} = skid_out;
  assign done = done_q;

`ifdef DMAW_WGEN_LASTCHK_EN
  assign err = err_q;
`else
  logic unused_src_last;
  assign unused_src_last = src_last;
  assign err = 1'b0;
`endif

endmodule

// File: doc/dmaw_wgen.md
DMAW_WGEN -- requirements
Module: dmaw_wgen

Interface
REQ-001 SHALL have parameters: AXI_DW, default 128, data bus width; AXI_BYTES, default AXI_DW/8, bytes per beat; BL, default 16, maximum burst beats; L, default $clog2(AXI_BYTES), byte-offset bits; B, default $clog2(BL)+L, burst-boundary bits.
REQ-002 SHALL use one clock and a synchronous, active-high reset: usr_clk and usr_reset.
REQ-003 Ports:
- usr_clk  in  1  clock
- usr_reset  in  1  sync active-high reset
- cfg_valid  in  1  job request
- cfg_ready  out  1  job accepted when high with cfg_valid
- cfg_sa  in  32  start byte address
- cfg_len  in  32  length in bytes
- src_data  in  AXI_DW  raw beat data
- src_last  in  1  producer end-of-job marker
- src_valid  in  1  beat valid
- src_ready  out  1  beat accepted
- usr_wdata  out  AXI_DW  beat to the AXI master user W port
- usr_wstrb  out  AXI_BYTES  byte strobes
- usr_wlast  out  1  last beat of burst
- usr_wvalid  out  1  beat valid
- usr_wready  in  1  beat accepted
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky src_last mismatch

Function
REQ-004 SHALL use FSM states IDLE, RUN and FLUSH; cfg_ready=1 only in IDLE.
REQ-005 On a cfg handshake in IDLE, SHALL latch sa and len.
- len=0: SHALL stay in IDLE and pulse done on the next cycle.
- Otherwise: SHALL enter RUN.
REQ-006 SHALL compute the total beat count as (sa[L-1:0]+len+AXI_BYTES-1)>>L using 33-bit arithmetic with no overflow.
REQ-007 SHALL keep a beat counter and a beat address; the address starts at sa with the low L bits cleared and increments by AXI_BYTES per accepted src beat.
REQ-008 Strobes:
- First beat: SHALL clear strobe bits below sa[L-1:0].
- Final beat: SHALL clear strobe bits at and above ((sa+len-1)[L-1:0])+1.
- Single-beat job: SHALL apply both masks.
- All other beats: SHALL drive all ones.
REQ-009 SHALL assert usr_wlast on a beat when (beat address + AXI_BYTES) is a multiple of 2^B, or when the beat is the final beat.
REQ-010 src beats SHALL pass through a 2-entry skid buffer to usr_*.
- Outputs come from registers; latency from src to usr is 1 cycle.
- Throughput is 1 beat per cycle under continuous usr_wready.
REQ-011 src_ready SHALL be 1 only in RUN while the skid buffer is not full and fewer than the total beats have been accepted.
REQ-012 After the final src beat is accepted, SHALL enter FLUSH; when the final usr beat handshakes, SHALL pulse done and return to IDLE.
REQ-013 usr_wvalid, once high, SHALL hold with stable data, strobe and last until usr_wready.
REQ-014 A simultaneous push and pop on a full buffer SHALL be legal and SHALL keep the occupancy unchanged.

Reset
REQ-015 usr_reset SHALL force the following, discarding any in-flight job and buffered beats, including a reset asserted mid-RUN or mid-FLUSH:
- FSM=IDLE; counters=0; skid buffer empty.
- usr_wvalid=0, usr_wlast=0, usr_wstrb=0, usr_wdata=0.
- src_ready=0, done=0, err=0; cfg_ready=1 from the first cycle after reset.

Configuration
REQ-016 With DMAW_WGEN_LASTCHK_EN defined:
- A src beat where src_last != (beat is final) SHALL set err.
- err SHALL stay set until usr_reset or the next cfg handshake.
- Beat flow SHALL be unaffected.
REQ-017 Without DMAW_WGEN_LASTCHK_EN: src_last SHALL be ignored and err SHALL be tied to 0.

Structure
REQ-018 A shared package dmaw_pkg SHALL hold:
- the FSM state enum;
- a function for beat-count computation;
- a function for the strobe mask from an offset and a direction.
REQ-019 The skid buffer SHALL be the sub-module dmaw_skid, parameterised on payload width AXI_DW+AXI_BYTES+1.

Verification (AXI_DW=128, so burst boundary = 256 B)
REQ-020 sa=0x1000, len=64 -> 4 beats, wstrb=0xFFFF on every beat, wlast on beat 4 only, done 1 cycle after the last usr handshake.
REQ-021 sa=0x1003, len=16 -> 2 beats; wstrb 0xFFF8 then 0x0007; wlast on beat 2.
REQ-022 sa=0x10F0, len=32 -> 2 beats, wlast=1 on both (boundary 0x1100).
REQ-023 sa=0, len=512, usr_wready alternating 1/0 -> 32 beats in order, wlast on beats 16 and 32, no lost or duplicated beats.
REQ-024 len=0 -> no usr_wvalid, done pulses 1 cycle after the handshake; then usr_reset asserted at beat 3 of a len=64 job -> all outputs at reset values the next cycle, and a new job runs cleanly.
REQ-025 With DMAW_WGEN_LASTCHK_EN, len=64 with src_last on beat 3 -> err=1 from the next cycle and 4 beats still delivered.
